shift_decode_counter: RTL and testbench

Parametrised successor to the shift-then-decode check used in the procedural exercises. The block:
- shifts each accepted input word right by a fixed amount;
- decodes the shifted value against NUM_CODES legal codes;
- flags any value that has no legal branch, instead of relying on a runtime unique-case warning.

It is a one-stage registered datapath with a valid/ready handshake and keeps saturating per-code hit counters plus a miss counter. Testbenches and small datapaths use it as a decode-coverage monitor.

---
 rtl/shift_decode_pkg.sv | 28 ++
 rtl/shift_decode_counter_sat_counter.sv | 38 +++
 rtl/shift_decode_counter.sv | 126 ++++++++++++
 tb/tb_shift_decode_counter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_decode_pkg.sv
// Shared types and helpers for the shift/decode coverage monitor.
// sd_shift is written over a fixed wide word so both hardware and models can call it.
package shift_decode_pkg;

   localparam int unsigned SD_MAX_W = 32;

   typedef logic [SD_MAX_W-1:0] sd_word_t;

   // All-ones value of a w-bit field, i.e. the saturation ceiling of a w-bit counter.
   function automatic sd_word_t sd_cnt_max(input int unsigned w);
      return (w >= SD_MAX_W) ? '1 : ((sd_word_t'(1) << w) - sd_word_t'(1));
   endfunction

   // Right shift of a width-bit value held in the low bits of a word; arith selects MSB fill.
   function automatic sd_word_t sd_shift(input sd_word_t value, input int unsigned width,
                                         input int unsigned shift, input bit arith);
      sd_word_t mask;
      sd_word_t v;
      mask = sd_cnt_max(width);
      v    = value & mask;
      if (arith && (((v >> (width - 1)) & sd_word_t'(1)) != '0)) begin
         v = v | ~mask;
      end
      v = sd_word_t'($signed(v) >>> shift);
      return v & mask;
   endfunction

endpackage

// File: rtl/shift_decode_counter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins first, then the increment applies.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   import shift_decode_pkg::*;

   localparam logic [W-1:0] CNT_MAX = W'(sd_cnt_max(W));

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end
      if (inc && (cnt_d != CNT_MAX)) begin
         cnt_d = cnt_d + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/shift_decode_counter.sv
// Shift-then-decode monitor: one registered stage with valid/ready handshake,
// saturating per-code hit counters, a miss counter and a sticky error flag.
module shift_decode_counter #(
   parameter int WIDTH     = 3,
   parameter int SHIFT     = 1,
   parameter int ARITH     = 0,
   parameter int NUM_CODES = 3,
   parameter int CNT_W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_code,
   output logic [NUM_CODES-1:0]       out_onehot,
   output logic                       out_nomatch,
   input  logic                       clear,
   output logic [NUM_CODES*CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0]           miss_cnt,
   output logic                       err_sticky
);
   import shift_decode_pkg::*;

   if ((SHIFT < 0) || (SHIFT >= WIDTH)) begin : g_bad_shift
      $error("shift_decode_counter: SHIFT must lie in 0..WIDTH-1");
   end
   if ((NUM_CODES < 1) || (NUM_CODES > (2 ** WIDTH))) begin : g_bad_codes
      $error("shift_decode_counter: NUM_CODES must lie in 1..2**WIDTH");
   end

   logic [WIDTH-1:0]     b;
   logic                 legal;
   logic                 accept;
   logic [NUM_CODES-1:0] onehot;
   logic [NUM_CODES-1:0] hit_inc;
   logic                 miss_inc;

   logic                 out_valid_q,   out_valid_d;
   logic [WIDTH-1:0]     out_code_q,    out_code_d;
   logic [NUM_CODES-1:0] out_onehot_q,  out_onehot_d;
   logic                 out_nomatch_q, out_nomatch_d;
   logic                 err_q,         err_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Decode: legal codes are compared at full word width so NUM_CODES == 2**WIDTH never overflows.
   always_comb begin
      b       = WIDTH'(sd_shift(SD_MAX_W'(in_data), WIDTH, SHIFT, ARITH != 0));
      legal   = SD_MAX_W'(b) < SD_MAX_W'(NUM_CODES);
      onehot  = '0;
      hit_inc = '0;
      for (int k = 0; k < NUM_CODES; k++) begin
         onehot[k]  = (SD_MAX_W'(b) == SD_MAX_W'(k));
         hit_inc[k] = accept && onehot[k];
      end
      miss_inc = accept && !legal;
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_code_d    = out_code_q;
      out_onehot_d  = out_onehot_q;
      out_nomatch_d = out_nomatch_q;
      err_d         = err_q;
      if (accept) begin
         out_valid_d   = 1'b1;
         out_code_d    = b;
         out_onehot_d  = onehot;
         out_nomatch_d = !legal;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (clear) begin
         err_d = 1'b0;
      end
      if (miss_inc) begin
         err_d = 1'b1;
      end
   end

   // Output stage register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q   <= 1'b0;
         out_code_q    <= '0;
         out_onehot_q  <= '0;
         out_nomatch_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_code_q    <= out_code_d;
         out_onehot_q  <= out_onehot_d;
         out_nomatch_q <= out_nomatch_d;
         err_q         <= err_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_code    = out_code_q;
   assign out_onehot  = out_onehot_q;
   assign out_nomatch = out_nomatch_q;
   assign err_sticky  = err_q;

   for (genvar k = 0; k < NUM_CODES; k++) begin : g_hit
      sat_counter #(.W(CNT_W)) u_hit (
         .clk (clk),
         .rst (rst),
         .clr (clear),
         .inc (hit_inc[k]),
         .q   (hit_cnt[k*CNT_W +: CNT_W])
      );
   end

   sat_counter #(.W(CNT_W)) u_miss (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (miss_inc),
      .q   (miss_cnt)
   );

endmodule

// File: tb/tb_shift_decode_counter.sv
// Bench for shift_decode_counter: scoreboarded default instance plus saturation and arithmetic-shift instances.
module tb_shift_decode_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Default instance
   logic        in_valid = 1'b0, out_ready = 1'b0, clear = 1'b0;
   logic [2:0]  in_data = '0;
   logic        in_ready, out_valid, out_nomatch, err_sticky;
   logic [2:0]  out_code, out_onehot;
   logic [23:0] hit_cnt;
   logic [7:0]  miss_cnt;

   shift_decode_counter u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_onehot(out_onehot),
      .out_nomatch(out_nomatch), .clear(clear), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
      .err_sticky(err_sticky)
   );

   // CNT_W=2 instance for saturation
   logic       s_valid = 1'b0;
   logic [2:0] s_data = '0;
   logic       s_in_ready, s_out_valid, s_nomatch, s_err;
   logic [2:0] s_code, s_onehot;
   logic [5:0] s_hit;
   logic [1:0] s_miss;

   shift_decode_counter #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .in_ready(s_in_ready),
      .out_valid(s_out_valid), .out_ready(1'b1), .out_code(s_code), .out_onehot(s_onehot),
      .out_nomatch(s_nomatch), .clear(1'b0), .hit_cnt(s_hit), .miss_cnt(s_miss),
      .err_sticky(s_err)
   );

   // Arithmetic shift, full legal space
   logic        a_valid = 1'b0;
   logic [2:0]  a_data = '0;
   logic        a_in_ready, a_out_valid, a_nomatch, a_err;
   logic [2:0]  a_code;
   logic [7:0]  a_onehot;
   logic [63:0] a_hit;
   logic [7:0]  a_miss;

   shift_decode_counter #(.ARITH(1), .NUM_CODES(8)) u_ari (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_ready(1'b1), .out_code(a_code), .out_onehot(a_onehot),
      .out_nomatch(a_nomatch), .clear(1'b0), .hit_cnt(a_hit), .miss_cnt(a_miss),
      .err_sticky(a_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard model of the default instance
   typedef struct packed {
      logic [2:0] code;
      logic [2:0] onehot;
      logic       nomatch;
   } exp_t;

   exp_t       sb_q[$];
   logic       mon_en  = 1'b0;
   logic       m_valid = 1'b0;
   logic       m_err   = 1'b0;
   logic [7:0] m_hit[3] = '{8'd0, 8'd0, 8'd0};
   logic [7:0] m_miss  = 8'd0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("mon_out_valid", out_valid, m_valid);
         check("mon_in_ready", in_ready, !m_valid || out_ready);
         for (int k = 0; k < 3; k++) begin
            check($sformatf("mon_hit%0d", k), hit_cnt[k*8 +: 8], m_hit[k]);
         end
         check("mon_miss", miss_cnt, m_miss);
         check("mon_err", err_sticky, m_err);
         if (m_valid) begin
            check("sb_depth", 64'(sb_q.size()), 64'd1);
            if (sb_q.size() > 0) begin
               check("sb_code", out_code, sb_q[0].code);
               check("sb_onehot", out_onehot, sb_q[0].onehot);
               check("sb_nomatch", out_nomatch, sb_q[0].nomatch);
            end
         end

         if (rst) begin
            sb_q.delete();
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_miss  = 8'd0;
            for (int k = 0; k < 3; k++) m_hit[k] = 8'd0;
         end else begin
            automatic logic acc = in_valid && (!m_valid || out_ready);
            automatic logic [2:0] bb = in_data >> 1;
            automatic exp_t e;
            if (m_valid && out_ready) begin
               if (sb_q.size() > 0) void'(sb_q.pop_front());
               m_valid = 1'b0;
            end
            if (clear) begin
               m_err  = 1'b0;
               m_miss = 8'd0;
               for (int k = 0; k < 3; k++) m_hit[k] = 8'd0;
            end
            if (acc) begin
               e.code    = bb;
               e.nomatch = (bb >= 3'd3);
               e.onehot  = (bb < 3'd3) ? (3'b001 << bb) : 3'b000;
               sb_q.push_back(e);
               m_valid = 1'b1;
               if (bb < 3'd3) begin
                  if (m_hit[bb[1:0]] != 8'hFF) m_hit[bb[1:0]] = m_hit[bb[1:0]] + 8'd1;
               end else begin
                  if (m_miss != 8'hFF) m_miss = m_miss + 8'd1;
                  m_err = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      // Reset state
      tick;
      mon_en = 1'b1;
      tick;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_code", out_code, 0);
      check("rst_out_onehot", out_onehot, 0);
      check("rst_out_nomatch", out_nomatch, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      check("rst_err", err_sticky, 0);
      check("pkg_shift_arith", shift_decode_pkg::sd_shift(32'd6, 3, 1, 1'b1), 64'd7);
      check("pkg_shift_logic", shift_decode_pkg::sd_shift(32'd6, 3, 1, 1'b0), 64'd3);
      rst = 1'b0;
      tick;

      // 1: streaming 1..7 at full throughput
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int d = 1; d <= 7; d++) begin
         in_data = 3'(d);
         tick;
      end
      in_valid = 1'b0;
      tick;
      check("t1_hit_cnt", hit_cnt, {8'd2, 8'd2, 8'd1});
      check("t1_miss_cnt", miss_cnt, 8'd2);
      check("t1_err", err_sticky, 1);

      // 2: backpressure
      clear = 1'b1;
      tick;
      clear     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 3'd4;
      for (int c = 0; c < 3; c++) begin
         tick;
         check("t2_hold_valid", out_valid, 1);
         check("t2_hold_code", out_code, 3'd2);
         check("t2_hold_onehot", out_onehot, 3'b100);
         check("t2_hold_ready", in_ready, 0);
      end
      check("t2_hit2_once", hit_cnt[23:16], 8'd1);
      out_ready = 1'b1;
      in_data   = 3'd2;
      #1;
      check("t2_ready_up", in_ready, 1);
      tick;
      check("t2_next_code", out_code, 3'd1);
      check("t2_ready_stays", in_ready, 1);
      in_valid = 1'b0;
      tick;
      check("t2_drained", out_valid, 0);

      // 3: saturation with CNT_W=2
      s_valid = 1'b1;
      s_data  = 3'd0;
      for (int i = 1; i <= 6; i++) begin
         tick;
         check("t3_sat_hit0", s_hit[1:0], (i > 3) ? 64'd3 : 64'(i));
      end
      s_valid = 1'b0;

      // 4: clear coincident with a nomatch accept
      clear = 1'b1;
      tick;
      clear    = 1'b0;
      in_valid = 1'b1;
      in_data  = 3'd6;
      tick;
      in_data = 3'd7;
      tick;
      check("t4_pre_miss", miss_cnt, 8'd2);
      clear   = 1'b1;
      in_data = 3'd6;
      tick;
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t4_miss", miss_cnt, 8'd1);
      check("t4_err", err_sticky, 1);
      check("t4_hits", hit_cnt, 0);
      check("t4_code", out_code, 3'd3);

      // 5: arithmetic shift, all codes legal
      a_valid = 1'b1;
      a_data  = 3'b110;
      tick;
      a_valid = 1'b0;
      check("t5_code", a_code, 3'b111);
      check("t5_onehot", a_onehot, 8'h80);
      check("t5_nomatch", a_nomatch, 0);
      check("t5_hit7", a_hit[63:56], 8'd1);
      check("t5_miss", a_miss, 8'd0);

      // 6: reset while a result is pending
      tick;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 3'd2;
      tick;
      tick;
      check("t6_pending", out_valid, 1);
      rst     = 1'b1;
      in_data = 3'd0;
      tick;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_code", out_code, 0);
      check("t6_rst_onehot", out_onehot, 0);
      check("t6_rst_nomatch", out_nomatch, 0);
      check("t6_rst_hits", hit_cnt, 0);
      check("t6_rst_miss", miss_cnt, 0);
      check("t6_rst_err", err_sticky, 0);
      out_ready = 1'b1;
      tick;
      check("t6_rst_no_accept", out_valid, 0);
      check("t6_rst_no_count", hit_cnt, 0);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("t6_ready_after", in_ready, 1);
      tick;
      tick;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
